// File: rtl/cell_heap_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cell_heap_if                                                    |
// | Purpose  : Request/response bundle of the alloc/free/rd/wr cell-memory     |
// |            protocol. "master" is the requester (bench or actor logic);     |
// |            "slave" is the responder (cell_heap).                           |
// | Signals  : i_alloc  alloc strobe          i_data  init / write data        |
// |            i_free   free strobe           i_addr  target ext. address      |
// |            i_rd     read strobe           i_wr    write strobe             |
// |            o_addr   last alloc address    o_data  read data                |
// |            o_done   completion pulse      o_busy  request in progress      |
// |            o_err    sticky error flag                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cell_heap_if #(
  parameter int DATA_SZ = 16
);
  logic               i_alloc;
  logic [DATA_SZ-1:0] i_data;
  logic [15:0]        o_addr;
  logic               i_free;
  logic [15:0]        i_addr;
  logic               i_rd;
  logic               i_wr;
  logic [DATA_SZ-1:0] o_data;
  logic               o_done;
  logic               o_busy;
  logic               o_err;

  modport master (
    output i_alloc, i_data, i_free, i_addr, i_rd, i_wr,
    input  o_addr, o_data, o_done, o_busy, o_err
  );

  modport slave (
    input  i_alloc, i_data, i_free, i_addr, i_rd, i_wr,
    output o_addr, o_data, o_done, o_busy, o_err
  );
endinterface
`default_nettype wire

// File: rtl/cell_heap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cell_heap                                                       |
// | Purpose  : Cell allocator. Owns a 2^ADDR_SZ-entry single-port RAM and a    |
// |            LIFO free-list threaded through the data words of free cells.   |
// |            Services one-cycle alloc / free / alloc+free (swap) / rd / wr   |
// |            strobes, pulses o_done on completion, keeps a sticky o_err.     |
// | Ports    : i_clk  system clock                                             |
// |            i_rst  asynchronous reset, active high                          |
// |            bus    cell_heap_if.slave (strobes, addresses, data, status)    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cell_heap #(
  parameter int          DATA_SZ   = 16,
  parameter int          ADDR_SZ   = 8,
  parameter logic [15:0] BASE_ADDR = 16'h5000
) (
  input  wire logic  i_clk,
  input  wire logic  i_rst,
  cell_heap_if.slave bus
);

  localparam int               c_DEPTH   = 1 << ADDR_SZ;
  // top == c_TOP_MAX means every index has been handed out at least once
  localparam logic [ADDR_SZ:0] c_TOP_MAX = {1'b1, {ADDR_SZ{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_SZ-1:0]   r_head;
  logic [ADDR_SZ:0]     r_top;
  logic [ADDR_SZ-1:0]   r_link;
  logic [15:0]          r_addr;
  logic [DATA_SZ-1:0]   r_data;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_err;
  logic [DATA_SZ-1:0]   r_mem [c_DEPTH];

  // ---------------------------------------------------------------- decode
  logic [ADDR_SZ-1:0] w_idx;
  logic               w_addr_ok;
  logic [2:0]         w_nstrb;
  logic               w_any;
  logic               w_single;
  logic               w_swap;
  logic               w_accept;
  logic               w_alloc_only;
  logic               w_need_addr;

  assign w_idx     = bus.i_addr[ADDR_SZ-1:0];
  assign w_addr_ok = (bus.i_addr[15:ADDR_SZ] == BASE_ADDR[15:ADDR_SZ]) &&
                     (w_idx != '0) && ({1'b0, w_idx} < r_top);

  assign w_nstrb  = {2'b0, bus.i_alloc} + {2'b0, bus.i_free} +
                    {2'b0, bus.i_rd}    + {2'b0, bus.i_wr};
  assign w_any    = (w_nstrb != 3'd0);
  assign w_single = (w_nstrb == 3'd1);
  assign w_swap   = bus.i_alloc & bus.i_free & ~bus.i_rd & ~bus.i_wr;
  // DONE is a completion-only state, so new requests are taken there too
  assign w_accept = (r_state != S_POP);

  assign w_alloc_only = w_accept & w_single & bus.i_alloc;
  assign w_need_addr  = w_accept & (w_swap | (w_single & ~bus.i_alloc));

  logic w_do_alloc_pop;
  logic w_do_alloc_new;
  logic w_alloc_full;
  logic w_do_free;
  logic w_do_swap;
  logic w_do_rd;
  logic w_do_wr;
  logic w_set_err;

  assign w_do_alloc_pop = w_alloc_only & (r_head != '0);
  assign w_do_alloc_new = w_alloc_only & (r_head == '0) & (r_top != c_TOP_MAX);
  assign w_alloc_full   = w_alloc_only & (r_head == '0) & (r_top == c_TOP_MAX);
  assign w_do_swap      = w_accept & w_swap & w_addr_ok;
  assign w_do_free      = w_accept & w_single & bus.i_free & w_addr_ok;
  assign w_do_rd        = w_accept & w_single & bus.i_rd   & w_addr_ok;
  assign w_do_wr        = w_accept & w_single & bus.i_wr   & w_addr_ok;

  assign w_set_err = (w_any & ~w_accept)
                   | (w_accept & w_any & ~w_single & ~w_swap)
                   | w_alloc_full
                   | (w_need_addr & ~w_addr_ok);

  // ---------------------------------------------------------------- RAM port
  logic [ADDR_SZ-1:0] w_ram_idx;
  logic               w_ram_we;
  logic [DATA_SZ-1:0] w_ram_wdata;
  logic [DATA_SZ-1:0] w_ram_rdata;

  always_comb begin
    w_ram_idx = w_idx;
    if (w_do_alloc_pop) begin
      w_ram_idx = r_head;
    end else if (w_do_alloc_new) begin
      w_ram_idx = r_top[ADDR_SZ-1:0];
    end
  end

  assign w_ram_we    = w_do_alloc_pop | w_do_alloc_new | w_do_free | w_do_swap | w_do_wr;
  // A freed cell stores the previous head: that is the free-list link
  assign w_ram_wdata = w_do_free ? DATA_SZ'(r_head) : bus.i_data;
  // Sampled into registers on the same edge as the write: read-before-write
  assign w_ram_rdata = r_mem[w_ram_idx];

  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= w_ram_wdata;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_top   <= {{ADDR_SZ{1'b0}}, 1'b1};
      r_link  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_POP: begin
          r_head  <= r_link;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          if (w_do_alloc_pop) begin
            // Old contents of the head cell are the next free index
            r_link  <= w_ram_rdata[ADDR_SZ-1:0];
            r_addr  <= BASE_ADDR | 16'(r_head);
            r_busy  <= 1'b1;
            r_state <= S_POP;
          end else if (w_do_alloc_new) begin
            r_addr  <= BASE_ADDR | 16'(r_top[ADDR_SZ-1:0]);
            r_top   <= r_top + 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_do_free) begin
            r_head  <= w_idx;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_do_swap) begin
            r_addr  <= bus.i_addr;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_do_rd) begin
            r_data  <= w_ram_rdata;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_do_wr) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
      endcase
    end
  end

  assign bus.o_addr = r_addr;
  assign bus.o_data = r_data;
  assign bus.o_done = r_done;
  assign bus.o_busy = r_busy;
  assign bus.o_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cell_heap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cell_heap                                                    |
// | Purpose  : Scoreboard bench for cell_heap. dut_a uses ADDR_SZ=8, dut_b     |
// |            ADDR_SZ=2 (exhaustion). sel routes the strobes to one of them.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cell_heap;

  localparam int K_NONE = 0;  // no completion expected
  localparam int K_ADDR = 1;  // completion, check o_addr
  localparam int K_DATA = 2;  // completion, check o_data
  localparam int K_DONE = 3;  // completion, latency only

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] val;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        sel;
  logic        s_alloc, s_free, s_rd, s_wr;
  logic [15:0] s_data, s_addr;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cell_heap_if #(.DATA_SZ(16)) ifa ();
  cell_heap_if #(.DATA_SZ(16)) ifb ();

  assign ifa.i_alloc = s_alloc & ~sel;
  assign ifa.i_free  = s_free  & ~sel;
  assign ifa.i_rd    = s_rd    & ~sel;
  assign ifa.i_wr    = s_wr    & ~sel;
  assign ifa.i_data  = s_data;
  assign ifa.i_addr  = s_addr;
  assign ifb.i_alloc = s_alloc & sel;
  assign ifb.i_free  = s_free  & sel;
  assign ifb.i_rd    = s_rd    & sel;
  assign ifb.i_wr    = s_wr    & sel;
  assign ifb.i_data  = s_data;
  assign ifb.i_addr  = s_addr;

  cell_heap #(.DATA_SZ(16), .ADDR_SZ(8), .BASE_ADDR(16'h5000)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .bus(ifa)
  );
  cell_heap #(.DATA_SZ(16), .ADDR_SZ(2), .BASE_ADDR(16'h5000)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .bus(ifb)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per o_done pulse
  always @(negedge clk) begin
    if (ifa.o_done === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_spurious_done", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        check({ea.name, "_latency"}, 32'(cyc), 32'(ea.due));
        if (ea.kind == K_ADDR) check(ea.name, 32'(ifa.o_addr), 32'(ea.val));
        else if (ea.kind == K_DATA) check(ea.name, 32'(ifa.o_data), 32'(ea.val));
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.o_done === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_spurious_done", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        check({eb.name, "_latency"}, 32'(cyc), 32'(eb.due));
        if (eb.kind == K_ADDR) check(eb.name, 32'(ifb.o_addr), 32'(eb.val));
        else if (eb.kind == K_DATA) check(eb.name, 32'(ifb.o_data), 32'(eb.val));
      end
    end
  end

  task automatic clear_strobes();
    s_alloc = 1'b0; s_free = 1'b0; s_rd = 1'b0; s_wr = 1'b0;
  endtask

  // One-cycle strobe; the expected completion is queued as it is issued
  task automatic op(input string nm, input bit a, input bit f, input bit r, input bit w,
                    input logic [15:0] addr, input logic [15:0] data,
                    input int kind, input logic [15:0] ev, input int lat);
    exp_t e;
    @(negedge clk);
    s_alloc = a; s_free = f; s_rd = r; s_wr = w; s_addr = addr; s_data = data;
    if (kind != K_NONE) begin
      e.name = nm; e.kind = kind; e.val = ev; e.due = cyc + lat;
      if (sel) qb.push_back(e); else qa.push_back(e);
    end
    @(negedge clk);
    clear_strobes();
  endtask

  task automatic pulse_rst_a();
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
  endtask

  logic [15:0] bad_rd [3];
  exp_t        ep;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bad_rd[0] = 16'h6001; bad_rd[1] = 16'h5000; bad_rd[2] = 16'h5002;
    sel = 1'b0; clear_strobes(); s_addr = '0; s_data = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("rst_o_addr", 32'(ifa.o_addr), 32'h0);
    check("rst_o_data", 32'(ifa.o_data), 32'h0);
    check("rst_o_done", 32'(ifa.o_done), 32'h0);
    check("rst_o_busy", 32'(ifa.o_busy), 32'h0);
    check("rst_o_err",  32'(ifa.o_err),  32'h0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // T1: fresh allocations come from top in order
    op("t1_alloc1", 1,0,0,0, 16'h0, 16'h0001, K_ADDR, 16'h5001, 1);
    op("t1_alloc2", 1,0,0,0, 16'h0, 16'h0002, K_ADDR, 16'h5002, 1);
    op("t1_alloc3", 1,0,0,0, 16'h0, 16'h0003, K_ADDR, 16'h5003, 1);
    op("t1_alloc4", 1,0,0,0, 16'h0, 16'h0004, K_ADDR, 16'h5004, 1);
    op("t1_rd5003", 0,0,1,0, 16'h5003, 16'h0, K_DATA, 16'h0003, 1);

    // T2: LIFO reuse through the free list
    op("t2_free5002", 0,1,0,0, 16'h5002, 16'h0, K_DONE, 16'h0, 1);
    op("t2_free5004", 0,1,0,0, 16'h5004, 16'h0, K_DONE, 16'h0, 1);
    op("t2_allocAA", 1,0,0,0, 16'h0, 16'h00AA, K_ADDR, 16'h5004, 2);
    check("t2_busy_in_pop", 32'(ifa.o_busy), 32'h1);
    op("t2_allocBB", 1,0,0,0, 16'h0, 16'h00BB, K_ADDR, 16'h5002, 2);
    op("t2_allocCC", 1,0,0,0, 16'h0, 16'h00CC, K_ADDR, 16'h5005, 1);
    op("t2_rd5004", 0,0,1,0, 16'h5004, 16'h0, K_DATA, 16'h00AA, 1);
    check("t2_no_err", 32'(ifa.o_err), 32'h0);

    // T5: swap leaves the free list alone; strobe during POP is an error
    op("t5_swap", 1,1,0,0, 16'h5001, 16'h0055, K_ADDR, 16'h5001, 1);
    op("t5_rd5001", 0,0,1,0, 16'h5001, 16'h0, K_DATA, 16'h0055, 1);
    op("t5_alloc_top", 1,0,0,0, 16'h0, 16'h0077, K_ADDR, 16'h5006, 1);
    op("t5_free5003", 0,1,0,0, 16'h5003, 16'h0, K_DONE, 16'h0, 1);
    check("t5_err_before", 32'(ifa.o_err), 32'h0);
    @(negedge clk);
    s_alloc = 1'b1; s_data = 16'h0099;
    ep.name = "t5_alloc_pop"; ep.kind = K_ADDR; ep.val = 16'h5003; ep.due = cyc + 2;
    qa.push_back(ep);
    @(negedge clk);
    check("t5_busy", 32'(ifa.o_busy), 32'h1);
    s_data = 16'h00EE;  // alloc still asserted: strobe while busy
    @(negedge clk);
    clear_strobes();
    check("t5_err_busy_strobe", 32'(ifa.o_err), 32'h1);
    op("t5_rd5003", 0,0,1,0, 16'h5003, 16'h0, K_DATA, 16'h0099, 1);

    // T4: invalid addresses raise o_err and are dropped
    for (int i = 0; i < 3; i++) begin
      pulse_rst_a();
      check("t4_err_cleared", 32'(ifa.o_err), 32'h0);
      op("t4_alloc", 1,0,0,0, 16'h0, 16'h0011, K_ADDR, 16'h5001, 1);
      op("t4_bad_rd", 0,0,1,0, bad_rd[i], 16'h0, K_NONE, 16'h0, 1);
      check("t4_bad_rd_err", 32'(ifa.o_err), 32'h1);
    end
    op("t4_bad_wr", 0,0,0,1, 16'h6001, 16'hBAD0, K_NONE, 16'h0, 1);
    op("t4_rd_unchanged", 0,0,1,0, 16'h5001, 16'h0, K_DATA, 16'h0011, 1);
    op("t4_wr5001", 0,0,0,1, 16'h5001, 16'h1234, K_DONE, 16'h0, 1);
    op("t4_rd5001", 0,0,1,0, 16'h5001, 16'h0, K_DATA, 16'h1234, 1);
    op("t4_combo", 0,0,1,1, 16'h5001, 16'h0, K_NONE, 16'h0, 1);

    // T6: reset during POP aborts the alloc and empties the heap
    pulse_rst_a();
    op("t6_alloc1", 1,0,0,0, 16'h0, 16'h0001, K_ADDR, 16'h5001, 1);
    op("t6_alloc2", 1,0,0,0, 16'h0, 16'h0002, K_ADDR, 16'h5002, 1);
    op("t6_free5001", 0,1,0,0, 16'h5001, 16'h0, K_DONE, 16'h0, 1);
    @(negedge clk);
    s_alloc = 1'b1; s_data = 16'h0042;
    @(negedge clk);
    clear_strobes();
    check("t6_busy", 32'(ifa.o_busy), 32'h1);
    #1 rst_a = 1'b1;
    #1;
    check("t6_rst_o_addr", 32'(ifa.o_addr), 32'h0);
    check("t6_rst_o_data", 32'(ifa.o_data), 32'h0);
    check("t6_rst_o_done", 32'(ifa.o_done), 32'h0);
    check("t6_rst_o_busy", 32'(ifa.o_busy), 32'h0);
    check("t6_rst_o_err",  32'(ifa.o_err),  32'h0);
    @(negedge clk);
    rst_a = 1'b0;
    op("t6_alloc_after", 1,0,0,0, 16'h0, 16'h0003, K_ADDR, 16'h5001, 1);

    // T3: ADDR_SZ=2 holds three cells, the fourth alloc fails
    sel = 1'b1;
    op("t3_alloc1", 1,0,0,0, 16'h0, 16'h0001, K_ADDR, 16'h5001, 1);
    op("t3_alloc2", 1,0,0,0, 16'h0, 16'h0002, K_ADDR, 16'h5002, 1);
    op("t3_alloc3", 1,0,0,0, 16'h0, 16'h0003, K_ADDR, 16'h5003, 1);
    check("t3_err_before", 32'(ifb.o_err), 32'h0);
    op("t3_alloc4", 1,0,0,0, 16'h0, 16'h0004, K_NONE, 16'h0, 1);
    check("t3_err_full", 32'(ifb.o_err), 32'h1);
    check("t3_addr_held", 32'(ifb.o_addr), 32'h5003);
    sel = 1'b0;

    repeat (4) @(negedge clk);
    check("qa_drained", 32'(qa.size()), 32'h0);
    check("qb_drained", 32'(qb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
